stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control and display-hold stage between the millisecond timer and the six hexDriver instances.
- Debounces three raw push-buttons (start/stop, lap, clear) and runs a 4-state stopwatch FSM.
- Drives the timer's run enable and clear pulse.
- Forwards either the live 30-bit time or a frozen lap value to the display path.
- Runs on the 50 MHz clkIn; the 1 kHz clkOut from clockDiv arrives as a sampled tick input.

Parameters:
- DEBOUNCE_MS, 20, consecutive 1 ms ticks a synced button level must hold before it is accepted.
- WIDTH, 30, width of time bus (six 5-bit display fields).

Ports:
- clkIn  input  1  50 MHz system clock
- resetN  input  1  reset; asynchronous, active-low
- tickIn  input  1  1 kHz square wave from clockDiv; asynchronous to clkIn
- btnStartStop  input  1  raw button, active-high
- btnLap  input  1  raw button, active-high
- btnClear  input  1  raw button, active-high
- timeIn  input  WIDTH  live count from timer
- runEn  output  1  timer count enable
- clearOut  output  1  one-clkIn-cycle timer clear pulse
- timeOut  output  WIDTH  value to hexDrivers ([29:25] to hex5 … [4:0] to hex0)
- lapActive  output  1  high while display is frozen on lap value
- state  output  2  FSM state code

Behaviour:
- Reset (resetN low, async): state=IDLE, runEn=0, clearOut=0, timeOut=0, lapActive=0. Lap register, sync flops, debounce counters and stable levels all 0.
- Tick sync:
  - tickIn passes through a 2-flop synchronizer plus an edge register.
  - tickPulse is high for exactly one clkIn cycle per tickIn rising edge.
- Button sync: each button passes through its own 2-flop synchronizer.
- Debounce, per button, with a counter wide enough for DEBOUNCE_MS:
  - When synced level equals stable level, the counter is 0.
  - Otherwise the counter increments on each tickPulse.
  - When the counter reaches DEBOUNCE_MS, stable takes the synced level and the counter returns to 0.
  - Any return to the stable level before the limit zeroes the counter, so glitches are rejected.
- Press events: a rising edge of a stable level is a one-cycle press event. Falling edges produce nothing.
- FSM state codes: IDLE=00, RUN=01, STOP=10, LAP=11.
- Event priority in one cycle: clear > startStop > lap. Lower-priority events that cycle are dropped.
- IDLE: runEn=0.
  - startStop → RUN.
  - clear → stay IDLE and pulse clearOut.
  - lap ignored.
- RUN: runEn=1.
  - startStop → STOP.
  - lap → LAP; lapReg ← timeIn in the same edge.
  - clear ignored.
- LAP: runEn=1 (timer keeps counting), lapActive=1.
  - lap → RUN (release).
  - startStop → STOP (freeze live value, lap released).
  - clear ignored.
- STOP: runEn=0.
  - startStop → RUN.
  - clear → IDLE with clearOut=1 for one cycle.
  - lap ignored.
- runEn, lapActive and state are registered; they change on the clkIn edge after the press event.
- timeOut is registered, 1-cycle latency:
  - timeOut ← lapReg when the next state is LAP.
  - Otherwise timeOut ← timeIn.
- Mid-operation reset returns everything to reset values immediately. Buttons still held at release produce a press once the debounce limit elapses.
- No arithmetic on time values; WIDTH bits pass unmodified.

Optional Feature:
- Macro: STOPWATCH_LAP_COUNT_EN
- Defined:
  - Adds output lapCount (4 bits), which increments on each RUN→LAP entry and saturates at 15.
  - Zeroed by reset and whenever clearOut pulses.
- Undefined: no lapCount port or register; all other behaviour identical.

Test Plan:
- Reset with resetN=0 mid-RUN → within the same cycle runEn=0, state=00, timeOut=0, clearOut=0.
- DEBOUNCE_MS=2; btnStartStop held through 3 tickPulses → one press, IDLE→RUN, runEn=1. A 1-tick glitch → no transition.
- In RUN, timeIn=30'd12345, press lap → state=11, timeOut stays 12345 while timeIn advances to 12400. Second lap → timeOut tracks timeIn again one cycle later.
- In LAP, press startStop → state=10, runEn=0, lapActive=0, timeOut=timeIn frozen.
- In STOP, press clear and startStop together → clear wins: state=00, clearOut high exactly 1 cycle.
- With STOPWATCH_LAP_COUNT_EN: 17 RUN→LAP entries → lapCount=15. Clear from STOP → lapCount=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: push-button debounce, stopwatch FSM and display hold stage
// sitting between the millisecond timer and the six hexDriver instances.
// Optional feature macro: STOPWATCH_LAP_COUNT_EN adds a saturating 4-bit
// lapCount output that counts RUN->LAP entries and is zeroed by clearOut.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int WIDTH       = 30
) (
  input  logic             clkIn,
  input  logic             resetN,
  input  logic             tickIn,
  input  logic             btnStartStop,
  input  logic             btnLap,
  input  logic             btnClear,
  input  logic [WIDTH-1:0] timeIn,
  output logic             runEn,
  output logic             clearOut,
  output logic [WIDTH-1:0] timeOut,
  output logic             lapActive,
`ifdef STOPWATCH_LAP_COUNT_EN
  output logic [3:0]       lapCount,
`endif
  output logic [1:0]       state
);

  localparam int CNT_W = (DEBOUNCE_MS < 1) ? 1 : $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  // Button bit positions inside the 3-bit button vectors.
  localparam int B_SS  = 0;
  localparam int B_LAP = 1;
  localparam int B_CLR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } swState_t;

  logic             tickMeta_r;
  logic             tickSync_r;
  logic             tickPrev_r;
  logic             tickPulse_s;

  logic [2:0]       btnRaw_s;
  logic [2:0]       btnMeta_r;
  logic [2:0]       btnSync_r;
  logic [2:0]       stable_r;
  logic [2:0]       stablePrev_r;
  logic [2:0]       press_s;
  logic [CNT_W-1:0] dbCnt_r [3];

  logic             evClear_s;
  logic             evStartStop_s;
  logic             evLap_s;

  swState_t         state_r;
  swState_t         nextState_s;
  logic             clearPulse_s;
  logic             captureLap_s;

  logic             runEn_r;
  logic             clearOut_r;
  logic             lapActive_r;
  logic [WIDTH-1:0] timeOut_r;
  logic [WIDTH-1:0] lapReg_r;

  logic             runEnNext_s;
  logic             lapActiveNext_s;
  logic [WIDTH-1:0] timeNext_s;

`ifdef STOPWATCH_LAP_COUNT_EN
  logic [3:0]       lapCount_r;
  logic [3:0]       lapCountNext_s;
`endif

  assign btnRaw_s    = {btnClear, btnLap, btnStartStop};
  assign tickPulse_s = tickSync_r & ~tickPrev_r;
  assign press_s     = stable_r & ~stablePrev_r;

  // Clear outranks start/stop, which outranks lap; losers are dropped.
  assign evClear_s     = press_s[B_CLR];
  assign evStartStop_s = press_s[B_SS] & ~press_s[B_CLR];
  assign evLap_s       = press_s[B_LAP] & ~press_s[B_SS] & ~press_s[B_CLR];

  // Synchronise the 1 kHz tick and the raw buttons into the clkIn domain.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      tickMeta_r <= 1'b0;
      tickSync_r <= 1'b0;
      tickPrev_r <= 1'b0;
      btnMeta_r  <= 3'b000;
      btnSync_r  <= 3'b000;
    end else begin
      tickMeta_r <= tickIn;
      tickSync_r <= tickMeta_r;
      tickPrev_r <= tickSync_r;
      btnMeta_r  <= btnRaw_s;
      btnSync_r  <= btnMeta_r;
    end
  end

  // Per-button debounce: a new level must persist for DEBOUNCE_MS ticks.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      stable_r     <= 3'b000;
      stablePrev_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        dbCnt_r[i] <= CNT_ZERO;
      end
    end else begin
      stablePrev_r <= stable_r;
      for (int i = 0; i < 3; i++) begin
        if (btnSync_r[i] == stable_r[i]) begin
          dbCnt_r[i] <= CNT_ZERO;
        end else if (dbCnt_r[i] == CNT_LIMIT) begin
          stable_r[i] <= btnSync_r[i];
          dbCnt_r[i]  <= CNT_ZERO;
        end else if (tickPulse_s) begin
          dbCnt_r[i] <= dbCnt_r[i] + CNT_ONE;
        end else begin
          dbCnt_r[i] <= dbCnt_r[i];
        end
      end
    end
  end

  // FSM state register together with the registered outputs and lap hold.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      runEn_r     <= 1'b0;
      clearOut_r  <= 1'b0;
      lapActive_r <= 1'b0;
      timeOut_r   <= {WIDTH{1'b0}};
      lapReg_r    <= {WIDTH{1'b0}};
`ifdef STOPWATCH_LAP_COUNT_EN
      lapCount_r  <= 4'd0;
`endif
    end else begin
      state_r     <= nextState_s;
      runEn_r     <= runEnNext_s;
      clearOut_r  <= clearPulse_s;
      lapActive_r <= lapActiveNext_s;
      timeOut_r   <= timeNext_s;
      if (captureLap_s) begin
        lapReg_r <= timeIn;
      end else begin
        lapReg_r <= lapReg_r;
      end
`ifdef STOPWATCH_LAP_COUNT_EN
      lapCount_r  <= lapCountNext_s;
`endif
    end
  end

  // Next-state logic: react only to the single winning press event.
  always_comb begin
    nextState_s  = state_r;
    clearPulse_s = 1'b0;
    captureLap_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (evClear_s) begin
          clearPulse_s = 1'b1;
        end else if (evStartStop_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (evStartStop_s) begin
          nextState_s = STOP;
        end else if (evLap_s) begin
          nextState_s  = LAP;
          captureLap_s = 1'b1;
        end else begin
          nextState_s = RUN;
        end
      end
      LAP: begin
        if (evStartStop_s) begin
          nextState_s = STOP;
        end else if (evLap_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = LAP;
        end
      end
      STOP: begin
        if (evClear_s) begin
          nextState_s  = IDLE;
          clearPulse_s = 1'b1;
        end else if (evStartStop_s) begin
          nextState_s = RUN;
        end else begin
          nextState_s = STOP;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs land with the state change.
  always_comb begin
    runEnNext_s     = 1'b0;
    lapActiveNext_s = 1'b0;
    timeNext_s      = timeIn;
    case (nextState_s)
      RUN: begin
        runEnNext_s = 1'b1;
      end
      LAP: begin
        runEnNext_s     = 1'b1;
        lapActiveNext_s = 1'b1;
        // On the entry edge lapReg is still loading, so show timeIn directly.
        if (captureLap_s) begin
          timeNext_s = timeIn;
        end else begin
          timeNext_s = lapReg_r;
        end
      end
      default: begin
        runEnNext_s     = 1'b0;
        lapActiveNext_s = 1'b0;
        timeNext_s      = timeIn;
      end
    endcase
  end

`ifdef STOPWATCH_LAP_COUNT_EN
  // Lap counter: saturating count of RUN->LAP entries, cleared with the timer.
  always_comb begin
    lapCountNext_s = lapCount_r;
    if (clearPulse_s) begin
      lapCountNext_s = 4'd0;
    end else if (captureLap_s && (lapCount_r != 4'd15)) begin
      lapCountNext_s = lapCount_r + 4'd1;
    end else begin
      lapCountNext_s = lapCount_r;
    end
  end

  assign lapCount = lapCount_r;
`endif

  assign runEn     = runEn_r;
  assign clearOut  = clearOut_r;
  assign lapActive = lapActive_r;
  assign timeOut   = timeOut_r;
  assign state     = state_r;

endmodule
